ultrasonic_distance_top: RTL and testbench

- Top-level controller for an HC-SR04-style ultrasonic ranger.
- A push-button request fires one trigger pulse, times the sensor's echo pulse, and converts the width to centimetres.
- The result is presented as three BCD digits (0–999 cm) for a downstream 7-segment driver.
- Single clock domain; the button and echo inputs are asynchronous and are synchronized internally.

---
 rtl/ultrasonic_pkg.sv | 22 ++
 rtl/bcd_counter3.sv | 55 +++++
 rtl/ultrasonic_distance_top.sv | 184 ++++++++++++++++++
 tb/tb_ultrasonic_distance_top.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_pkg.sv
// Shared types and default timing for the ultrasonic ranger.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitEcho,
    StMeasure,
    StDone
  } state_e;

  // Defaults assume a 50 MHz clock.
  localparam int unsigned DefTrigCycles   = 500;
  localparam int unsigned DefCyclesPerCm  = 2900;
  localparam int unsigned DefTimeoutCycles = 1900000;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BcdNine  = 4'd9;
  localparam bcd_t OorDigit = 4'd9;

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit cascaded BCD counter, saturating at 999, with synchronous clear.
module bcd_counter3
  import ultrasonic_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output bcd_t bcd0,
  output bcd_t bcd1,
  output bcd_t bcd2
);

  bcd_t d0_q, d1_q, d2_q;
  bcd_t d0_d, d1_d, d2_d;
  logic at_max;

  // Clear and increment in the same cycle yields 001.
  always_comb begin
    d0_d   = clear ? '0 : d0_q;
    d1_d   = clear ? '0 : d1_q;
    d2_d   = clear ? '0 : d2_q;
    at_max = (d0_d == BcdNine) && (d1_d == BcdNine) && (d2_d == BcdNine);
    if (inc && !at_max) begin
      if (d0_d == BcdNine) begin
        d0_d = '0;
        if (d1_d == BcdNine) begin
          d1_d = '0;
          d2_d = d2_d + 4'd1;
        end else begin
          d1_d = d1_d + 4'd1;
        end
      end else begin
        d0_d = d0_d + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d0_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      d0_q <= d0_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
    end
  end

  assign bcd0 = d0_q;
  assign bcd1 = d1_q;
  assign bcd2 = d2_q;

endmodule

// File: rtl/ultrasonic_distance_top.sv
// HC-SR04 style ranger: button fires a trigger pulse, echo width is converted to BCD centimetres.
module ultrasonic_distance_top
  import ultrasonic_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = DefTrigCycles,
  parameter int unsigned CYCLES_PER_CM  = DefCyclesPerCm,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic B,
  input  logic echo,
  output logic trigger,
  output bcd_t bcd0,
  output bcd_t bcd1,
  output bcd_t bcd2
);

  localparam int unsigned TrigW = $clog2(TRIG_CYCLES + 1);
  localparam int unsigned PreW  = $clog2(CYCLES_PER_CM + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TrigW-1:0] TrigLast = TrigW'(TRIG_CYCLES - 1);
  localparam logic [PreW-1:0]  PreLast  = PreW'(CYCLES_PER_CM - 1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);

  logic b_meta_q, b_sync_q, b_prev_q;
  logic echo_meta_q, echo_sync_q, echo_prev_q;
  logic b_rise, echo_rise, echo_fall;

  state_e state_q, state_d;
  logic [TrigW-1:0] trig_cnt_q, trig_cnt_d;
  logic [PreW-1:0]  pre_q, pre_d, pre_base;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic             oor_q, oor_d;
  logic             trigger_q, trigger_d;
  bcd_t             out0_q, out1_q, out2_q;
  bcd_t             out0_d, out1_d, out2_d;
  logic             cnt_clear, cnt_inc;
  bcd_t             cnt0, cnt1, cnt2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_meta_q    <= 1'b0;
      b_sync_q    <= 1'b0;
      b_prev_q    <= 1'b0;
      echo_meta_q <= 1'b0;
      echo_sync_q <= 1'b0;
      echo_prev_q <= 1'b0;
    end else begin
      b_meta_q    <= B;
      b_sync_q    <= b_meta_q;
      b_prev_q    <= b_sync_q;
      echo_meta_q <= echo;
      echo_sync_q <= echo_meta_q;
      echo_prev_q <= echo_sync_q;
    end
  end

  assign b_rise    = b_sync_q & ~b_prev_q;
  assign echo_rise = echo_sync_q & ~echo_prev_q;
  assign echo_fall = ~echo_sync_q & echo_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (b_rise) state_d = StTrig;
      StTrig:     if (trig_cnt_q == TrigLast) state_d = StWaitEcho;
      StWaitEcho: begin
        if (echo_rise) state_d = StMeasure;
        else if (tmo_q == TmoLast) state_d = StDone;
      end
      StMeasure:  if (echo_fall || (tmo_q == TmoLast)) state_d = StDone;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // The echo_rise cycle is itself a high cycle, so counting starts there from a zero base.
  always_comb begin
    trigger_d  = (state_d == StTrig);
    trig_cnt_d = '0;
    tmo_d      = '0;
    pre_d      = pre_q;
    oor_d      = oor_q;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    out0_d     = out0_q;
    out1_d     = out1_q;
    out2_d     = out2_q;
    pre_base   = (state_q == StWaitEcho) ? '0 : pre_q;
    case (state_q)
      StIdle: oor_d = 1'b0;
      StTrig: trig_cnt_d = trig_cnt_q + 1'b1;
      StWaitEcho: begin
        tmo_d = tmo_q + 1'b1;
        if (echo_rise) begin
          tmo_d     = '0;
          cnt_clear = 1'b1;
          if (pre_base == PreLast) begin
            pre_d   = '0;
            cnt_inc = 1'b1;
          end else begin
            pre_d = pre_base + 1'b1;
          end
        end else if (tmo_q == TmoLast) begin
          oor_d = 1'b1;
        end
      end
      StMeasure: begin
        tmo_d = tmo_q + 1'b1;
        if (echo_sync_q) begin
          if (pre_base == PreLast) begin
            pre_d   = '0;
            cnt_inc = 1'b1;
          end else begin
            pre_d = pre_base + 1'b1;
          end
        end
        if (echo_fall) begin
          out0_d = cnt0;
          out1_d = cnt1;
          out2_d = cnt2;
        end else if (tmo_q == TmoLast) begin
          oor_d = 1'b1;
        end
      end
      StDone: begin
        if (oor_q) begin
          out0_d = OorDigit;
          out1_d = OorDigit;
          out2_d = OorDigit;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_cnt_q <= '0;
      pre_q      <= '0;
      tmo_q      <= '0;
      oor_q      <= 1'b0;
      trigger_q  <= 1'b0;
      out0_q     <= '0;
      out1_q     <= '0;
      out2_q     <= '0;
    end else begin
      trig_cnt_q <= trig_cnt_d;
      pre_q      <= pre_d;
      tmo_q      <= tmo_d;
      oor_q      <= oor_d;
      trigger_q  <= trigger_d;
      out0_q     <= out0_d;
      out1_q     <= out1_d;
      out2_q     <= out2_d;
    end
  end

  bcd_counter3 u_bcd_counter3 (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .bcd0  (cnt0),
    .bcd1  (cnt1),
    .bcd2  (cnt2)
  );

  assign trigger = trigger_q;
  assign bcd0    = out0_q;
  assign bcd1    = out1_q;
  assign bcd2    = out2_q;

endmodule

// File: tb/tb_ultrasonic_distance_top.sv
// Randomized self-checking bench for ultrasonic_distance_top with short timing parameters.
module tb_ultrasonic_distance_top;

  localparam int unsigned TbTrig = 2;
  localparam int unsigned TbCpc  = 4;
  localparam int unsigned TbTmo  = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       B = 1'b0;
  logic       echo = 1'b0;
  logic       trigger;
  logic [3:0] bcd0, bcd1, bcd2;

  int n_pass = 0;
  int n_total = 0;

  ultrasonic_distance_top #(
    .TRIG_CYCLES    (TbTrig),
    .CYCLES_PER_CM  (TbCpc),
    .TIMEOUT_CYCLES (TbTmo)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .B       (B),
    .echo    (echo),
    .trigger (trigger),
    .bcd0    (bcd0),
    .bcd1    (bcd1),
    .bcd2    (bcd2)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // Reference: distance in cm is the floor of high time over cycles-per-cm, clipped at 999.
  function automatic logic [11:0] model_digits(input int unsigned high_cycles, input bit oor);
    int unsigned d;
    d = oor ? 999 : high_cycles / TbCpc;
    if (d > 999) d = 999;
    return {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic echo_pulse(input int n);
    echo = 1'b1;
    repeat (n) tick();
    echo = 1'b0;
  endtask

  // Press B and follow the trigger pulse; returns cycles until trigger and its high width.
  task automatic press_and_trigger(input bit hold, output int lat, output int width);
    B = 1'b1;
    lat = 0;
    while (!trigger && lat < 20) begin
      tick();
      lat++;
      if (!hold && lat == 2) B = 1'b0;
    end
    if (!hold) B = 1'b0;
    width = 0;
    while (trigger && width < 50) begin
      tick();
      width++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    n_total++;
    if (trigger !== 1'b0) $display("FAIL reset_trigger: got %b, required 0", trigger);
    else n_pass++;
    n_total++;
    if ({bcd2, bcd1, bcd0} !== 12'h000)
      $display("FAIL reset_digits: got %h, required 000", {bcd2, bcd1, bcd0});
    else n_pass++;
  endtask

  task automatic test_nominal();
    int lat, width;
    press_and_trigger(1'b0, lat, width);
    n_total++;
    if (lat < 1 || lat > 4) $display("FAIL nominal_latency: got %0d, required 1..4", lat);
    else n_pass++;
    n_total++;
    if (width != TbTrig) $display("FAIL nominal_trig_width: got %0d, required %0d", width, TbTrig);
    else n_pass++;
    echo_pulse(40);
    repeat (6) tick();
    n_total++;
    if ({bcd2, bcd1, bcd0} !== model_digits(40, 1'b0))
      $display("FAIL nominal_digits: got %h, required %h", {bcd2, bcd1, bcd0},
               model_digits(40, 1'b0));
    else n_pass++;
    repeat (30) tick();
    n_total++;
    if ({bcd2, bcd1, bcd0} !== model_digits(40, 1'b0))
      $display("FAIL nominal_hold: got %h, required %h", {bcd2, bcd1, bcd0},
               model_digits(40, 1'b0));
    else n_pass++;
  endtask

  task automatic test_floor();
    int widths[3] = '{43, 4, 3};
    int lat, width;
    foreach (widths[i]) begin
      press_and_trigger(1'b0, lat, width);
      echo_pulse(widths[i]);
      repeat (6) tick();
      n_total++;
      if ({bcd2, bcd1, bcd0} !== model_digits(widths[i], 1'b0))
        $display("FAIL floor_%0d: got %h, required %h", widths[i], {bcd2, bcd1, bcd0},
                 model_digits(widths[i], 1'b0));
      else n_pass++;
      repeat (3) tick();
    end
  endtask

  task automatic test_async_reset();
    int lat, width;
    press_and_trigger(1'b0, lat, width);
    echo_pulse(40);
    repeat (6) tick();
    #3 rst = 1'b0;
    #1;
    n_total++;
    if ({bcd2, bcd1, bcd0} !== 12'h000)
      $display("FAIL async_reset_digits: got %h, required 000", {bcd2, bcd1, bcd0});
    else n_pass++;
    @(negedge clk) rst = 1'b1;
    tick();
  endtask

  task automatic test_no_echo();
    int lat, width;
    press_and_trigger(1'b0, lat, width);
    repeat (TbTmo + 10) tick();
    n_total++;
    if ({bcd2, bcd1, bcd0} !== model_digits(0, 1'b1))
      $display("FAIL no_echo_oor: got %h, required %h", {bcd2, bcd1, bcd0},
               model_digits(0, 1'b1));
    else n_pass++;
    press_and_trigger(1'b0, lat, width);
    n_total++;
    if (width != TbTrig) $display("FAIL no_echo_retrigger: got width %0d, required %0d",
                                  width, TbTrig);
    else n_pass++;
    echo_pulse(40);
    repeat (6) tick();
    n_total++;
    if ({bcd2, bcd1, bcd0} !== model_digits(40, 1'b0))
      $display("FAIL no_echo_recover: got %h, required %h", {bcd2, bcd1, bcd0},
               model_digits(40, 1'b0));
    else n_pass++;
  endtask

  task automatic test_ignored();
    int lat, width, trig_seen;
    trig_seen = 0;
    for (int p = 0; p < 3; p++) begin
      echo = 1'b1;
      repeat (10) begin tick(); if (trigger) trig_seen++; end
      echo = 1'b0;
      repeat (5) begin tick(); if (trigger) trig_seen++; end
    end
    n_total++;
    if ({bcd2, bcd1, bcd0} !== model_digits(40, 1'b0) || trig_seen != 0)
      $display("FAIL idle_echo: got %h trig %0d, required %h trig 0", {bcd2, bcd1, bcd0},
               trig_seen, model_digits(40, 1'b0));
    else n_pass++;

    press_and_trigger(1'b0, lat, width);
    trig_seen = 0;
    echo = 1'b1;
    repeat (10) tick();
    B = 1'b1;
    repeat (2) begin tick(); if (trigger) trig_seen++; end
    B = 1'b0;
    repeat (20) begin tick(); if (trigger) trig_seen++; end
    echo = 1'b0;
    repeat (16) begin tick(); if (trigger) trig_seen++; end
    n_total++;
    if (trig_seen != 0) $display("FAIL b_in_measure_trigger: got %0d, required 0", trig_seen);
    else n_pass++;
    n_total++;
    if ({bcd2, bcd1, bcd0} !== model_digits(32, 1'b0))
      $display("FAIL b_in_measure_digits: got %h, required %h", {bcd2, bcd1, bcd0},
               model_digits(32, 1'b0));
    else n_pass++;

    press_and_trigger(1'b1, lat, width);
    echo_pulse(20);
    trig_seen = 0;
    repeat (40) begin tick(); if (trigger) trig_seen++; end
    B = 1'b0;
    n_total++;
    if (trig_seen != 0 || width != TbTrig)
      $display("FAIL held_b: got retriggers %0d width %0d, required 0 and %0d", trig_seen,
               width, TbTrig);
    else n_pass++;
    n_total++;
    if ({bcd2, bcd1, bcd0} !== model_digits(20, 1'b0))
      $display("FAIL held_b_digits: got %h, required %h", {bcd2, bcd1, bcd0},
               model_digits(20, 1'b0));
    else n_pass++;
    repeat (4) tick();
  endtask

  task automatic test_abort();
    int lat, width;
    press_and_trigger(1'b0, lat, width);
    echo = 1'b1;
    repeat (20) tick();
    #2 rst = 1'b0;
    #1;
    n_total++;
    if ({bcd2, bcd1, bcd0} !== 12'h000 || trigger !== 1'b0)
      $display("FAIL abort: got digits %h trigger %b, required 000 and 0", {bcd2, bcd1, bcd0},
               trigger);
    else n_pass++;
    echo = 1'b0;
    @(negedge clk) rst = 1'b1;
    repeat (3) tick();
    press_and_trigger(1'b0, lat, width);
    echo_pulse(40);
    repeat (6) tick();
    n_total++;
    if ({bcd2, bcd1, bcd0} !== model_digits(40, 1'b0))
      $display("FAIL abort_recover: got %h, required %h", {bcd2, bcd1, bcd0},
               model_digits(40, 1'b0));
    else n_pass++;
  endtask

  task automatic test_random();
    int lat, width, n, pre;
    for (int it = 0; it < 12; it++) begin
      repeat ($urandom_range(0, 5)) tick();
      n   = int'($urandom_range(1, 70));
      pre = int'($urandom_range(0, 20));
      press_and_trigger(1'b0, lat, width);
      n_total++;
      if (width != TbTrig || lat > 4)
        $display("FAIL random_trig_%0d: got lat %0d width %0d, required <=4 and %0d", it, lat,
                 width, TbTrig);
      else n_pass++;
      repeat (pre) tick();
      echo_pulse(n);
      repeat (6) tick();
      n_total++;
      if ({bcd2, bcd1, bcd0} !== model_digits(n, 1'b0))
        $display("FAIL random_digits_%0d (width %0d): got %h, required %h", it, n,
                 {bcd2, bcd1, bcd0}, model_digits(n, 1'b0));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_floor();
    test_async_reset();
    test_no_echo();
    test_ignored();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
